// File: rtl/rf_pkg.sv
// Shared defaults and types for the integer register file with pending-write scoreboard.
package rf_pkg;
  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int CNT_W_DEF = 2;
  localparam int CNT_MAX   = 2**CNT_W_DEF - 1;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;
endpackage

// File: rtl/rf_pending_ctr.sv
// Saturating up/down count of in-flight writes to one register.
module rf_pending_ctr #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, inc_ok, dec_ok;

  assign empty  = (count_q == '0);
  assign full   = &count_q;
  assign inc_ok = inc && !full;
  assign dec_ok = dec && !empty;

  always_comb begin
    count_d = count_q;
    if (inc_ok && !dec_ok) count_d = count_q + CNT_W'(1);
    else if (dec_ok && !inc_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // A retirement with nothing outstanding means the pipeline lost track of a write.
  assign underflow = dec && empty;
  assign count     = count_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file (x0 hardwired to zero) with per-register pending-write counters
// so decode can stall on RAW hazards; optional write-back to read forwarding.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int  XLEN   = XLEN_DEF,
  parameter int  NREGS  = NREGS_DEF,
  parameter int  NRD    = 2,
  parameter int  CNT_W  = CNT_W_DEF,
  parameter int  BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_addr,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  output logic                err_underflow
);
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [CNT_W-1:0] cnt    [NREGS];
  logic [NREGS-1:0] wb_hit, busy, full, uf;
  logic             err_underflow_q, err_underflow_d;

  assign cnt[0]    = '0;
  assign wb_hit[0] = 1'b0;
  assign busy[0]   = 1'b0;
  assign full[0]   = 1'b0;
  assign uf[0]     = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_ctr
    logic inc, dec;
    assign inc = issue_valid && issue_ready && (issue_addr == AW'(r));
    assign dec = wb_valid && (wb_addr == AW'(r));

    rf_pending_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clock     (clock),
      .reset     (reset),
      .inc       (inc),
      .dec       (dec),
      .count     (cnt[r]),
      .underflow (uf[r])
    );

    assign wb_hit[r] = dec && (cnt[r] != '0);
    assign full[r]   = &cnt[r];
    // Busy reflects this cycle's retirement but not this cycle's issue.
    assign busy[r]   = (cnt[r] - CNT_W'(wb_hit[r])) != '0;
  end

  // Saturation uses the current count; a same-cycle retirement does not free a slot.
  assign issue_ready = (issue_addr == '0) || !full[issue_addr];

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] != '0) begin
        rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
        if (BYPASS != 0 && wb_valid && wb_addr == rd_addr[i*AW +: AW])
          rd_data[i*XLEN +: XLEN] = wb_data;
        rd_busy[i] = busy[rd_addr[i*AW +: AW]];
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_valid && wb_addr != '0) regs_d[wb_addr] = wb_data;
    regs_d[0] = '0;
  end

  assign err_underflow_d = err_underflow_q || (|uf);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q          <= '{default: '0};
      err_underflow_q <= 1'b0;
    end else begin
      regs_q          <= regs_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_underflow = err_underflow_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard, with a second instance built without forwarding.
module tb_regfile_scoreboard;
  import rf_pkg::*;

  localparam int NRD = 2;
  localparam int AW  = AW_DEF;
  localparam int XL  = XLEN_DEF;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XL-1:0]   rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic                issue_valid = 1'b0;
  reg_addr_t           issue_addr = '0;
  logic                issue_ready, issue_ready_nb;
  logic                wb_valid = 1'b0;
  reg_addr_t           wb_addr = '0;
  xdata_t              wb_data = '0;
  logic                err, err_nb;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  regfile_scoreboard #(.XLEN(XL), .NREGS(NREGS_DEF), .NRD(NRD), .CNT_W(CNT_W_DEF), .BYPASS(1)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .err_underflow(err)
  );

  regfile_scoreboard #(.XLEN(XL), .NREGS(NREGS_DEF), .NRD(NRD), .CNT_W(CNT_W_DEF), .BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready_nb),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .err_underflow(err_nb)
  );

  typedef struct {
    logic [4:0]  rd0, rd1;
    logic        iv;
    logic [4:0]  ia;
    logic        wv;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [63:0] e0, e1;
    logic [1:0]  eb;
    logic        er, ee;
  } vec_t;

  localparam int NV = 23;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd0, input logic [4:0] rd1, input logic iv,
                       input logic [4:0] ia, input logic wv, input logic [4:0] wa,
                       input logic [63:0] wd);
    rd_addr     = {rd1, rd0};
    issue_valid = iv;
    issue_addr  = ia;
    wb_valid    = wv;
    wb_addr     = wa;
    wb_data     = wd;
  endtask

  initial begin
    logic [63:0] ones;
    ones = '1;
    //           rd0 rd1 iv ia wv wa wd                 e0                 e1          eb     er ee
    vec[0]  = '{5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0,           64'h0,           64'h0,      2'b00, 1'b1, 1'b0};
    vec[1]  = '{5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 5'd0, 64'h0,           64'h0,           64'h0,      2'b00, 1'b1, 1'b0};
    vec[2]  = '{5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 64'hDEAD_BEEF,   64'hDEAD_BEEF,   64'h0,      2'b00, 1'b1, 1'b0};
    vec[3]  = '{5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0,           64'hDEAD_BEEF,   64'hDEAD_BEEF, 2'b00, 1'b1, 1'b0};
    vec[4]  = '{5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 64'h0,           64'h0,           64'h0,      2'b00, 1'b1, 1'b0};
    vec[5]  = '{5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 64'h0,           64'h0,           64'h0,      2'b11, 1'b1, 1'b0};
    vec[6]  = '{5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 64'h0,           64'h0,           64'h0,      2'b11, 1'b1, 1'b0};
    vec[7]  = '{5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 64'h0,           64'h0,           64'h0,      2'b11, 1'b0, 1'b0};
    vec[8]  = '{5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 64'h0,           64'h0,           64'h0,      2'b11, 1'b0, 1'b0};
    vec[9]  = '{5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 64'h70,          64'h70,          64'h0,      2'b01, 1'b0, 1'b0};
    vec[10] = '{5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 64'h71,          64'h71,          64'h0,      2'b01, 1'b1, 1'b0};
    vec[11] = '{5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 64'h72,          64'h72,          64'h0,      2'b00, 1'b1, 1'b0};
    vec[12] = '{5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0,           64'h72,          64'h0,      2'b00, 1'b1, 1'b0};
    vec[13] = '{5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 64'h0,           64'h0,           64'h0,      2'b00, 1'b1, 1'b0};
    vec[14] = '{5'd9, 5'd0, 1'b1, 5'd9, 1'b1, 5'd9, 64'h99,          64'h99,          64'h0,      2'b00, 1'b1, 1'b0};
    vec[15] = '{5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0,           64'h99,          64'h0,      2'b01, 1'b1, 1'b0};
    vec[16] = '{5'd9, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 64'h9A,          64'h9A,          64'h0,      2'b00, 1'b1, 1'b0};
    vec[17] = '{5'd0, 5'd9, 1'b1, 5'd0, 1'b1, 5'd0, ones,            64'h0,           64'h9A,     2'b00, 1'b1, 1'b0};
    vec[18] = '{5'd0, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0,           64'h0,           64'h9A,     2'b00, 1'b1, 1'b0};
    vec[19] = '{5'd4, 5'd4, 1'b0, 5'd0, 1'b1, 5'd4, 64'h1234,        64'h1234,        64'h1234,   2'b00, 1'b1, 1'b0};
    vec[20] = '{5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0,           64'h1234,        64'h0,      2'b00, 1'b1, 1'b1};
    vec[21] = '{5'd0, 5'd4, 1'b0, 5'd0, 1'b1, 5'd0, ones,            64'h0,           64'h1234,   2'b00, 1'b1, 1'b1};
    vec[22] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0,           64'h0,           64'h0,      2'b00, 1'b1, 1'b1};

    // Held in reset: outputs must already be cleared.
    drive(5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0);
    #2;
    chk("rst.rd_data", rd_data, 64'h0);
    chk("rst.rd_busy", {62'h0, rd_busy}, 64'h0);
    chk("rst.err", {63'h0, err}, 64'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(negedge clock);
      drive(vec[k].rd0, vec[k].rd1, vec[k].iv, vec[k].ia, vec[k].wv, vec[k].wa, vec[k].wd);
      #1;
      chk($sformatf("v%0d.rd0", k), rd_data[63:0], vec[k].e0);
      chk($sformatf("v%0d.rd1", k), rd_data[127:64], vec[k].e1);
      chk($sformatf("v%0d.busy", k), {62'h0, rd_busy}, {62'h0, vec[k].eb});
      chk($sformatf("v%0d.ready", k), {63'h0, issue_ready}, {63'h0, vec[k].er});
      chk($sformatf("v%0d.err", k), {63'h0, err}, {63'h0, vec[k].ee});
    end

    // Forwarding versus no forwarding on x5 (both hold DEAD_BEEF from the table).
    @(negedge clock);
    drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 64'h0);
    @(negedge clock);
    drive(5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 64'h5555);
    #1;
    chk("byp.rd0", rd_data[63:0], 64'h5555);
    chk("nobyp.rd0_same", rd_data_nb[63:0], 64'hDEAD_BEEF);
    chk("nobyp.busy", {62'h0, rd_busy_nb}, 64'h0);
    chk("nobyp.ready", {63'h0, issue_ready_nb}, 64'h1);
    @(negedge clock);
    drive(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0);
    #1;
    chk("nobyp.rd0_next", rd_data_nb[63:0], 64'h5555);
    chk("nobyp.err", {63'h0, err_nb}, 64'h1);

    // Reset mid-run discards data, counts and the error flag.
    @(negedge clock);
    drive(5'd5, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 64'h0);
    @(negedge clock);
    drive(5'd5, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0);
    #1;
    chk("pre_rst.busy", {62'h0, rd_busy}, 64'h2);
    reset = 1'b1;
    #1;
    chk("mid_rst.rd_data", rd_data, 128'h0);
    chk("mid_rst.busy", {62'h0, rd_busy}, 64'h0);
    chk("mid_rst.err", {63'h0, err}, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(5'd3, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 64'h33);
    #1;
    chk("post_rst.rd0", rd_data[63:0], 64'h33);
    chk("post_rst.err_same", {63'h0, err}, 64'h0);
    @(negedge clock);
    drive(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0);
    #1;
    chk("post_rst.err_next", {63'h0, err}, 64'h1);
    chk("post_rst.rd0_next", rd_data[63:0], 64'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
